// File: rtl/inst_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inst_fetch : RV32I fetch stage with PC, IF/ID register, redirect and |
// |              sticky fetch-fault detection.                           |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module inst_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_DEPTH = 64
) (
  input  logic        iClk,
  input  logic        iRst_n,
  output logic [31:0] oInstAddr,
  input  logic [31:0] iInstData,
  input  logic        iRedirect,
  input  logic [31:0] iRedirectPc,
  output logic        oIdValid,
  input  logic        iIdReady,
  output logic [31:0] oIdPc,
  output logic [31:0] oIdPcPlus4,
  output logic [31:0] oIdInst,
  output logic        oFault,
  output logic [1:0]  oFaultCause,
  output logic [31:0] oFaultPc,
  output logic [31:0] oFetchCnt
);

  localparam logic [1:0]  c_st_boot   = 2'd0;
  localparam logic [1:0]  c_st_run    = 2'd1;
  localparam logic [1:0]  c_st_fault  = 2'd2;
  localparam logic [1:0]  c_cause_mis = 2'b01;
  localparam logic [1:0]  c_cause_oor = 2'b10;
  localparam logic [29:0] c_rom_words = 30'(ROM_DEPTH);

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic        r_id_valid;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_pc_plus4;
  logic [31:0] r_id_inst;
  logic        r_fault;
  logic [1:0]  r_fault_cause;
  logic [31:0] r_fault_pc;
  logic [31:0] r_fetch_cnt;

  logic w_load;
  logic w_handshake;
  logic w_misaligned;
  logic w_out_of_range;

  assign w_handshake    = r_id_valid & iIdReady;
  assign w_load         = ~r_id_valid | iIdReady;
  assign w_misaligned   = |iRedirectPc[1:0];
  assign w_out_of_range = r_pc[31:2] >= c_rom_words;

  assign oInstAddr   = r_pc;
  assign oIdValid    = r_id_valid;
  assign oIdPc       = r_id_pc;
  assign oIdPcPlus4  = r_id_pc_plus4;
  assign oIdInst     = r_id_inst;
  assign oFault      = r_fault;
  assign oFaultCause = r_fault_cause;
  assign oFaultPc    = r_fault_pc;
  assign oFetchCnt   = r_fetch_cnt;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state       <= c_st_boot;
      r_pc          <= RESET_PC;
      r_id_valid    <= 1'b0;
      r_id_pc       <= 32'd0;
      r_id_pc_plus4 <= 32'd0;
      r_id_inst     <= 32'd0;
      r_fault       <= 1'b0;
      r_fault_cause <= 2'b00;
      r_fault_pc    <= 32'd0;
      r_fetch_cnt   <= 32'd0;
    end else begin
      // Valid is forced low in FAULT, so counting every handshake also
      // covers the one completing on the fault-entry cycle.
      if (w_handshake) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      case (r_state)
        c_st_boot, c_st_run: begin
          if (iRedirect) begin
            r_id_valid <= 1'b0;
            if (w_misaligned) begin
              r_state       <= c_st_fault;
              r_fault       <= 1'b1;
              r_fault_cause <= c_cause_mis;
              r_fault_pc    <= iRedirectPc;
            end else begin
              r_pc    <= iRedirectPc;
              r_state <= c_st_run;
            end
          end else if (r_state == c_st_boot) begin
            r_state <= c_st_run;
          end else if (w_load) begin
            if (w_out_of_range) begin
              r_state       <= c_st_fault;
              r_id_valid    <= 1'b0;
              r_fault       <= 1'b1;
              r_fault_cause <= c_cause_oor;
              r_fault_pc    <= r_pc;
            end else begin
              r_id_pc       <= r_pc;
              r_id_pc_plus4 <= r_pc + 32'd4;
              r_id_inst     <= iInstData;
              r_id_valid    <= 1'b1;
              r_pc          <= r_pc + 32'd4;
            end
          end
        end
        default: begin
          r_id_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// Bench for inst_fetch: spec-level model compared every cycle plus directed
// literal expectations from the fetch/stall/redirect/fault scenarios.
module tb_inst_fetch;
  localparam int ROM_DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        id_ready = 1'b0;
  logic [31:0] inst_addr, inst_data, id_pc, id_pc4, id_inst, fault_pc, fetch_cnt;
  logic        id_valid, fault;
  logic [1:0]  fault_cause;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] rom [0:ROM_DEPTH-1];

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(32'h0000_0000), .ROM_DEPTH(ROM_DEPTH)) dut (
    .iClk(clk), .iRst_n(rst_n),
    .oInstAddr(inst_addr), .iInstData(inst_data),
    .iRedirect(redirect), .iRedirectPc(redirect_pc),
    .oIdValid(id_valid), .iIdReady(id_ready),
    .oIdPc(id_pc), .oIdPcPlus4(id_pc4), .oIdInst(id_inst),
    .oFault(fault), .oFaultCause(fault_cause), .oFaultPc(fault_pc),
    .oFetchCnt(fetch_cnt)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a < 32'(4 * ROM_DEPTH)) return rom[a[7:2]];
    return 32'hDEAD_BEEF;
  endfunction

  always_comb inst_data = rom_word(inst_addr);

  initial begin
    for (int i = 0; i < ROM_DEPTH; i++) rom[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0011;
  end

  // Reference model: fetch stage described in terms of its observable rules.
  logic        m_valid, m_boot, m_fault;
  logic [31:0] m_pc, m_idpc, m_idpc4, m_inst, m_fpc, m_cnt;
  logic [1:0]  m_cause;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_boot <= 1'b1; m_fault <= 1'b0;
      m_pc <= 32'd0; m_idpc <= 32'd0; m_idpc4 <= 32'd0; m_inst <= 32'd0;
      m_fpc <= 32'd0; m_cnt <= 32'd0; m_cause <= 2'b00;
    end else if (!m_fault) begin
      if (m_valid && id_ready) m_cnt <= m_cnt + 32'd1;
      m_boot <= 1'b0;
      if (redirect) begin
        m_valid <= 1'b0;
        if ((redirect_pc % 32'd4) != 32'd0) begin
          m_fault <= 1'b1; m_cause <= 2'b01; m_fpc <= redirect_pc;
        end else begin
          m_pc <= redirect_pc;
        end
      end else if (!m_boot && (!m_valid || id_ready)) begin
        if (m_pc >= 32'(4 * ROM_DEPTH)) begin
          m_fault <= 1'b1; m_cause <= 2'b10; m_fpc <= m_pc; m_valid <= 1'b0;
        end else begin
          m_idpc <= m_pc; m_idpc4 <= m_pc + 32'd4; m_inst <= rom_word(m_pc);
          m_valid <= 1'b1; m_pc <= m_pc + 32'd4;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_cmp();
    logic [195:0] a, e;
    a = {id_valid, id_pc, id_pc4, id_inst, fault, fault_cause, fault_pc, fetch_cnt, inst_addr};
    e = {m_valid, m_idpc, m_idpc4, m_inst, m_fault, m_cause, m_fpc, m_cnt, m_pc};
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL model t=%0t: actual=%h required=%h", $time, a, e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      model_cmp();
    end
  endtask

  initial begin
    int n;
    step(2);
    check("rst_valid", {31'd0, id_valid}, 32'd0);
    check("rst_addr", inst_addr, 32'h0);
    check("rst_cnt", fetch_cnt, 32'd0);

    // Sequential fetch with decode always ready
    id_ready = 1'b1; rst_n = 1'b1;
    step(1); check("boot_valid", {31'd0, id_valid}, 32'd0);
    step(1); check("c2_pc", id_pc, 32'h0); check("c2_inst", id_inst, 32'h1000_0000);
    step(1); check("c3_pc", id_pc, 32'h4); check("c3_pc4", id_pc4, 32'h8);
    check("c3_inst", id_inst, 32'h1001_0011); check("c3_cnt", fetch_cnt, 32'd1);
    step(1); check("c4_pc", id_pc, 32'h8); check("c4_cnt", fetch_cnt, 32'd2);

    // Three-cycle stall
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("stall_pc", id_pc, 32'h8); check("stall_addr", inst_addr, 32'hC);
      check("stall_inst", id_inst, 32'h1002_0022);
    end
    id_ready = 1'b1;
    step(1); check("rel_pc", id_pc, 32'hC); check("rel_cnt", fetch_cnt, 32'd3);
    step(1); check("c_pc10", id_pc, 32'h10); check("c_cnt4", fetch_cnt, 32'd4);

    // Redirect while held instruction is stalled: flushed, not counted
    id_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h48;
    step(1); redirect = 1'b0;
    check("rd_valid", {31'd0, id_valid}, 32'd0); check("rd_cnt", fetch_cnt, 32'd4);
    step(1); check("rd_pc", id_pc, 32'h48); check("rd_inst", id_inst, 32'h1012_0132);
    check("rd_cnt2", fetch_cnt, 32'd4);

    // Redirect coinciding with a handshake: counted
    id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h20;
    step(1); redirect = 1'b0; check("rdh_cnt", fetch_cnt, 32'd5);
    step(1); check("rdh_pc", id_pc, 32'h20);

    // Misaligned redirect
    redirect = 1'b1; redirect_pc = 32'h4A;
    step(1); redirect = 1'b0;
    check("mis_fault", {31'd0, fault}, 32'd1); check("mis_cause", {30'd0, fault_cause}, 32'd1);
    check("mis_fpc", fault_pc, 32'h4A); check("mis_valid", {31'd0, id_valid}, 32'd0);
    check("mis_cnt", fetch_cnt, 32'd6);
    redirect = 1'b1; redirect_pc = 32'h0;
    step(1); redirect = 1'b0;
    step(2);
    check("sticky_fault", {31'd0, fault}, 32'd1); check("frozen_addr", inst_addr, 32'h24);
    check("frozen_cnt", fetch_cnt, 32'd6);

    // Asynchronous reset clears the fault without a clock edge
    #2 rst_n = 1'b0;
    #1 model_cmp();
    check("ar_fault", {31'd0, fault}, 32'd0); check("ar_cause", {30'd0, fault_cause}, 32'd0);
    check("ar_fpc", fault_pc, 32'd0); check("ar_cnt", fetch_cnt, 32'd0);
    step(1);

    // Redirect during BOOT, then run off the end of the ROM
    rst_n = 1'b1; redirect = 1'b1; redirect_pc = 32'hF0;
    step(1); redirect = 1'b0;
    check("bootrd_valid", {31'd0, id_valid}, 32'd0); check("bootrd_addr", inst_addr, 32'hF0);
    n = 0;
    while (!(id_valid && id_pc == 32'hFC) && n < 20) begin step(1); n++; end
    check("reach_fc", id_pc, 32'hFC); check("fc_inst", id_inst, 32'h103F_042F);
    step(1);
    check("oor_fault", {31'd0, fault}, 32'd1); check("oor_cause", {30'd0, fault_cause}, 32'd2);
    check("oor_fpc", fault_pc, 32'h100); check("oor_cnt", fetch_cnt, 32'd4);

    // Async reset in the middle of a stall
    #3 rst_n = 1'b0;
    #1 model_cmp();
    step(1); rst_n = 1'b1;
    step(3);
    id_ready = 1'b0;
    step(2);
    check("pre_pc", id_pc, 32'h4);
    #3 rst_n = 1'b0;
    #1 model_cmp();
    check("ms_valid", {31'd0, id_valid}, 32'd0); check("ms_pc", id_pc, 32'd0);
    check("ms_inst", id_inst, 32'd0); check("ms_addr", inst_addr, 32'd0);
    check("ms_cnt", fetch_cnt, 32'd0);
    step(1); rst_n = 1'b1; id_ready = 1'b1;
    step(1); check("re_boot", {31'd0, id_valid}, 32'd0);
    step(1); check("re_pc", id_pc, 32'h0); check("re_inst", id_inst, 32'h1000_0000);

    // Misaligned and out of range at once: misalignment wins
    redirect = 1'b1; redirect_pc = 32'h201;
    step(1); redirect = 1'b0;
    check("both_cause", {30'd0, fault_cause}, 32'd1); check("both_fpc", fault_pc, 32'h201);

    // Aligned out-of-range redirect target faults on the next fetch
    rst_n = 1'b0;
    step(1); rst_n = 1'b1;
    step(2);
    redirect = 1'b1; redirect_pc = 32'h200;
    step(1); redirect = 1'b0;
    check("oort_fault0", {31'd0, fault}, 32'd0);
    step(1);
    check("oort_cause", {30'd0, fault_cause}, 32'd2); check("oort_fpc", fault_pc, 32'h200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- IF stage of the RV32I core. Holds the PC and drives the instruction ROM read address.
- Captures the combinational ROM word into an IF/ID register and hands {PC, PC+4, instruction} to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute and detects misaligned or out-of-range fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset
- ROM_DEPTH, 64, number of 32-bit words in the instruction ROM; legal PC range is [0, 4*ROM_DEPTH)

Ports:
- iClk  input  1  clock, rising edge
- iRst_n  input  1  asynchronous active-low reset
- oInstAddr  output  32  ROM read address; equals rPc combinationally
- iInstData  input  32  ROM read data, valid in the same cycle as oInstAddr
- iRedirect  input  1  branch/jump taken; single-cycle pulse from EX
- iRedirectPc  input  32  redirect target
- oIdValid  output  1  IF/ID register holds a valid instruction
- iIdReady  input  1  decode accepts the IF/ID contents this cycle
- oIdPc  output  32  PC of the held instruction
- oIdPcPlus4  output  32  oIdPc + 4
- oIdInst  output  32  held instruction word
- oFault  output  1  sticky fetch fault
- oFaultCause  output  2  01 = misaligned target, 10 = PC out of range, 00 = none
- oFaultPc  output  32  offending address
- oFetchCnt  output  32  count of accepted handshakes (oIdValid & iIdReady)

Behaviour:
- Reset (async, iRst_n=0):
  - rPc=RESET_PC, state=BOOT.
  - oIdValid=0; oIdPc, oIdPcPlus4, oIdInst=0. oIdInst resets to 0, not NOP; decode must gate on valid.
  - oFault=0, oFaultCause=0, oFaultPc=0, oFetchCnt=0.
  - Reset deasserted mid-operation restarts cleanly from RESET_PC; no partial state survives.
- States: BOOT, RUN, FAULT.
- BOOT: lasts exactly one cycle after reset release, with oIdValid=0. Transitions to RUN.
  - A redirect in BOOT is honoured: rPc<=iRedirectPc, subject to the fault checks below.
- RUN: define load = !oIdValid | iIdReady.
  - load=1: IF/ID<={rPc, rPc+4, iInstData}, oIdValid<=1, rPc<=rPc+4.
  - load=0 (stall): rPc and IF/ID hold; ROM address unchanged.
  - Fetch latency: an instruction appears on oIdInst one cycle after its address is on oInstAddr.
  - Back-to-back throughput is one instruction per cycle while iIdReady=1.
- Redirect (highest priority, any state except FAULT):
  - rPc<=iRedirectPc and oIdValid<=0, flushing the wrong-path instruction regardless of iIdReady.
  - If oIdValid & iIdReady in that same cycle, the handshake still counts in oFetchCnt.
  - The first target instruction is valid two cycles after the redirect pulse.
- Fault checks:
  - Before capture: rPc[31:2] >= ROM_DEPTH -> FAULT, cause 10, oFaultPc=rPc, no capture.
  - On redirect: iRedirectPc[1:0]!=0 -> FAULT, cause 01, oFaultPc=iRedirectPc, oIdValid<=0.
  - Misalignment has priority over range when both apply.
- Wrap: PC increment is modulo 2^32; the range check fires before any wrap is reachable.
- FAULT: sticky until reset.
  - oIdValid=0, rPc frozen, redirects ignored.
  - oFetchCnt frozen, except that a handshake completing on the fault-entry cycle is counted.
- oFetchCnt: +1 on each oIdValid & iIdReady cycle; wraps 32'hFFFF_FFFF -> 0.
- Outputs are registered, except oInstAddr, which is a direct wire from rPc.

Test Plan:
- Reset, then iIdReady=1 held → cycle 1 BOOT (valid=0); cycle 2 oIdPc=0x0; cycle 3 oIdPc=0x4, oIdPcPlus4=0x8, oIdInst=ROM[1]; oFetchCnt increments every cycle.
- iIdReady low for 3 cycles while oIdPc=0x8 → oIdInst, oIdPc, oInstAddr=0xC stable for 3 cycles; release → next oIdPc=0xC with no instruction skipped or duplicated.
- Redirect to 0x48 while oIdPc=0x10 is held and iIdReady=0 → next cycle oIdValid=0; following cycle oIdPc=0x48, oIdInst=ROM[18]; 0x10 is never accepted and oFetchCnt is unchanged.
- Redirect to 0x4A → oFault=1, oFaultCause=01, oFaultPc=0x4A, oIdValid=0; a later redirect to 0x0 is ignored; reset clears all fault outputs.
- Sequential run to PC=0xFC with ROM_DEPTH=64 → the 0xFC instruction is delivered; next cycle oFault=1, oFaultCause=10, oFaultPc=0x100.
- Assert iRst_n=0 asynchronously mid-stall (between clock edges) → outputs clear immediately without a clock edge; after release, refetch starts at RESET_PC.
